cpu_bus_serializer: RTL and testbench

//  Parametrised bridge from the CPU's parallel memory request port to a narrow bidirectional pin bus.
//  It frames each transfer as: CMD beat, address beats, then either write-data beats or read-data beats.

---
 rtl/cpu_bus_serializer_if.sv | 49 ++++
 rtl/cpu_bus_serializer.sv | 195 +++++++++++++++++++
 tb/tb_cpu_bus_serializer.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_serializer_if.sv
// ---------------------------------------------------------------------------
// cpu_bus_serializer_if
// Groups the CPU request/response port and the narrow pin bus of the
// cpu_bus_serializer bridge.
//
// Signals
//   req_valid/req_ready   request handshake (CPU -> bridge)
//   req_we/addr/wdata     request payload
//   rsp_valid/err/rdata   single-cycle response (bridge -> CPU)
//   pin_out/oe/frame      beat data, pad enables, CMD-beat marker (to pads)
//   pin_in/pin_ack        beat data and done strobe (from pads)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. The bridge raises req_ready only while idle and
// does not look at req_we/req_addr/req_wdata on any other cycle. Responses
// have no backpressure: rsp_valid is a one-cycle pulse that the CPU must
// take when it appears.
// ---------------------------------------------------------------------------
interface cpu_bus_serializer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int PIN_W  = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [PIN_W-1:0]  pin_out;
  logic [PIN_W-1:0]  pin_oe;
  logic              pin_frame;
  logic [PIN_W-1:0]  pin_in;
  logic              pin_ack;

  // CPU plus pad side: drives requests and incoming pin values.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, pin_in, pin_ack,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, pin_out, pin_oe, pin_frame
  );

  // Bridge side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, pin_in, pin_ack,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, pin_out, pin_oe, pin_frame
  );
endinterface

// File: rtl/cpu_bus_serializer.sv
// ---------------------------------------------------------------------------
// cpu_bus_serializer
// Bridges a parallel CPU memory request onto a narrow bidirectional pin bus.
// Each transfer is framed as one CMD beat, ceil(ADDR_W/PIN_W) address beats,
// then either ceil(DATA_W/PIN_W) write-data beats before waiting for
// pin_ack, or a wait for pin_ack followed by the same number of read-data
// beats. All beats are LSB-first. A missing ack ends the wait after TIMEOUT
// cycles with an error response.
//
// Ports
//   i_clk     clock, rising edge
//   i_rst     synchronous active-high reset
//   io_bus    request/response and pin bus signals (slave modport)
//   o_state   current FSM state, for observation
// ---------------------------------------------------------------------------
module cpu_bus_serializer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int PIN_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  cpu_bus_serializer_if.slave  io_bus,
  output logic [2:0]           o_state
);

  localparam int AB   = (ADDR_W + PIN_W - 1) / PIN_W;
  localparam int DB   = (DATA_W + PIN_W - 1) / PIN_W;
  localparam int MAXB = (AB > DB) ? AB : DB;
  localparam int BW   = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int WW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [BW-1:0] AB_LAST = BW'(AB - 1);
  localparam logic [BW-1:0] DB_LAST = BW'(DB - 1);
  localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_WDATA = 3'd3,
    S_WAIT  = 3'd4,
    S_RDATA = 3'd5,
    S_RESP  = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_we;
  logic [AB*PIN_W-1:0]   r_addr_sh;
  logic [DB*PIN_W-1:0]   r_wdata_sh;
  logic [DB*PIN_W-1:0]   r_rd_sh;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_err;
  logic [BW-1:0]         r_beat;
  logic [WW-1:0]         r_wcnt;

  logic [AB*PIN_W-1:0]   w_addr_ext;
  logic [DB*PIN_W-1:0]   w_wdata_ext;
  logic [DB*PIN_W-1:0]   w_rd_next;
  logic                  w_timeout;
  logic                  w_req_ready;
  logic                  w_rsp_valid;
  logic [PIN_W-1:0]      w_pin_out;
  logic [PIN_W-1:0]      w_pin_oe;
  logic                  w_pin_frame;

  // Zero-extend the payload to whole beats so the top beat is zero-padded.
  // Read beats enter at the top and move down, so after DB beats beat 0
  // lands in the least significant PIN_W bits; bits above DATA_W are dropped.
  always_comb begin
    w_addr_ext                 = '0;
    w_addr_ext[ADDR_W-1:0]     = io_bus.req_addr;
    w_wdata_ext                = '0;
    w_wdata_ext[DATA_W-1:0]    = io_bus.req_wdata;
    w_rd_next                  = r_rd_sh >> PIN_W;
    w_rd_next[DB*PIN_W-1 -: PIN_W] = io_bus.pin_in;
  end

  assign w_timeout = (r_wcnt == TO_LAST);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and Moore outputs. Outputs are forced to their reset values
  // while i_rst is high so the pads are released in the reset cycle itself.
  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_rsp_valid  = 1'b0;
    w_pin_out    = '0;
    w_pin_oe     = '0;
    w_pin_frame  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (io_bus.req_valid) w_state_next = S_CMD;
      end
      S_CMD: begin
        w_pin_out[1] = 1'b1;
        w_pin_out[0] = r_we;
        w_pin_oe     = '1;
        w_pin_frame  = 1'b1;
        w_state_next = S_ADDR;
      end
      S_ADDR: begin
        w_pin_out = r_addr_sh[PIN_W-1:0];
        w_pin_oe  = '1;
        if (r_beat == AB_LAST) w_state_next = r_we ? S_WDATA : S_WAIT;
      end
      S_WDATA: begin
        w_pin_out = r_wdata_sh[PIN_W-1:0];
        w_pin_oe  = '1;
        if (r_beat == DB_LAST) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        // Ack is checked first so an ack on the last allowed cycle wins.
        if (io_bus.pin_ack)  w_state_next = r_we ? S_RESP : S_RDATA;
        else if (w_timeout)  w_state_next = S_RESP;
      end
      S_RDATA: begin
        if (r_beat == DB_LAST) w_state_next = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid  = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (i_rst) begin
      w_req_ready = 1'b0;
      w_rsp_valid = 1'b0;
      w_pin_out   = '0;
      w_pin_oe    = '0;
      w_pin_frame = 1'b0;
    end
  end

  // Datapath: request latch, beat shifters, counters and response registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_we       <= 1'b0;
      r_addr_sh  <= '0;
      r_wdata_sh <= '0;
      r_rd_sh    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_beat     <= '0;
      r_wcnt     <= '0;
    end else begin
      // Beat index restarts whenever the state changes.
      r_beat <= (w_state_next != r_state) ? '0 : r_beat + BW'(1);
      // Wait counter is zero on the first WAIT cycle.
      r_wcnt <= (r_state == S_WAIT) ? r_wcnt + WW'(1) : '0;
      case (r_state)
        S_IDLE: begin
          if (io_bus.req_valid) begin
            r_we       <= io_bus.req_we;
            r_addr_sh  <= w_addr_ext;
            r_wdata_sh <= w_wdata_ext;
          end
        end
        S_ADDR:  r_addr_sh  <= r_addr_sh >> PIN_W;
        S_WDATA: r_wdata_sh <= r_wdata_sh >> PIN_W;
        S_WAIT: begin
          if (io_bus.pin_ack) begin
            r_err <= 1'b0;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
        S_RDATA: begin
          r_rd_sh <= w_rd_next;
          if (r_beat == DB_LAST) r_rdata <= w_rd_next[DATA_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign io_bus.req_ready = w_req_ready;
  assign io_bus.rsp_valid = w_rsp_valid;
  assign io_bus.rsp_err   = w_rsp_valid & r_err;
  assign io_bus.rsp_rdata = r_rdata;
  assign io_bus.pin_out   = w_pin_out;
  assign io_bus.pin_oe    = w_pin_oe;
  assign io_bus.pin_frame = w_pin_frame;
  assign o_state          = r_state;

endmodule

// File: tb/tb_cpu_bus_serializer.sv
module tb_cpu_bus_serializer;

  localparam int A_AB = 4;
  localparam int A_DB = 4;
  localparam int T_AB = 4;
  localparam int T_DB = 4;
  localparam int T_TO = 4;
  localparam int N_AB = 2;
  localparam int N_DB = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] a_state, t_state, n_state;
  int n_checks = 0;
  int n_errors = 0;

  cpu_bus_serializer_if #(.ADDR_W(32), .DATA_W(32), .PIN_W(8)) a_if ();
  cpu_bus_serializer_if #(.ADDR_W(32), .DATA_W(32), .PIN_W(8)) t_if ();
  cpu_bus_serializer_if #(.ADDR_W(12), .DATA_W(16), .PIN_W(8)) n_if ();

  cpu_bus_serializer #(.ADDR_W(32), .DATA_W(32), .PIN_W(8), .TIMEOUT(16)) dut_a (
    .i_clk(clk), .i_rst(rst), .io_bus(a_if), .o_state(a_state));
  cpu_bus_serializer #(.ADDR_W(32), .DATA_W(32), .PIN_W(8), .TIMEOUT(T_TO)) dut_t (
    .i_clk(clk), .i_rst(rst), .io_bus(t_if), .o_state(t_state));
  cpu_bus_serializer #(.ADDR_W(12), .DATA_W(16), .PIN_W(8), .TIMEOUT(16)) dut_n (
    .i_clk(clk), .i_rst(rst), .io_bus(n_if), .o_state(n_state));

  // ---------------- scoreboard ----------------
  logic [8:0]  a_beat_q[$];   // {frame, pin_out}
  logic [32:0] a_rsp_q[$];    // {err, rdata}
  logic [32:0] t_rsp_q[$];
  logic [8:0]  n_beat_q[$];
  logic [16:0] n_rsp_q[$];
  logic [31:0] a_last_rdata = '0;
  logic [8:0]  a_eb, n_eb;
  logic [32:0] a_er, t_er;
  logic [16:0] n_er;

  always @(negedge clk) begin
    if (a_if.pin_oe === 8'hFF) begin
      n_checks++;
      if (a_beat_q.size() == 0) begin
        n_errors++;
        $display("FAIL a_beat: unexpected beat frame=%b out=%h", a_if.pin_frame, a_if.pin_out);
      end else begin
        a_eb = a_beat_q.pop_front();
        if ({a_if.pin_frame, a_if.pin_out} !== a_eb) begin
          n_errors++;
          $display("FAIL a_beat: got frame=%b out=%h, expected frame=%b out=%h",
                   a_if.pin_frame, a_if.pin_out, a_eb[8], a_eb[7:0]);
        end
      end
    end else begin
      n_checks++;
      if (a_if.pin_oe !== 8'h00 || a_if.pin_out !== 8'h00 || a_if.pin_frame !== 1'b0) begin
        n_errors++;
        $display("FAIL a_idle_pins: oe=%h out=%h frame=%b, expected all zero",
                 a_if.pin_oe, a_if.pin_out, a_if.pin_frame);
      end
    end
    if (a_if.rsp_valid === 1'b1) begin
      n_checks++;
      if (a_rsp_q.size() == 0) begin
        n_errors++;
        $display("FAIL a_rsp: unexpected response err=%b rdata=%h", a_if.rsp_err, a_if.rsp_rdata);
      end else begin
        a_er = a_rsp_q.pop_front();
        if ({a_if.rsp_err, a_if.rsp_rdata} !== a_er) begin
          n_errors++;
          $display("FAIL a_rsp: got err=%b rdata=%h, expected err=%b rdata=%h",
                   a_if.rsp_err, a_if.rsp_rdata, a_er[32], a_er[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (t_if.rsp_valid === 1'b1) begin
      n_checks++;
      if (t_rsp_q.size() == 0) begin
        n_errors++;
        $display("FAIL t_rsp: unexpected response err=%b rdata=%h", t_if.rsp_err, t_if.rsp_rdata);
      end else begin
        t_er = t_rsp_q.pop_front();
        if ({t_if.rsp_err, t_if.rsp_rdata} !== t_er) begin
          n_errors++;
          $display("FAIL t_rsp: got err=%b rdata=%h, expected err=%b rdata=%h",
                   t_if.rsp_err, t_if.rsp_rdata, t_er[32], t_er[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (n_if.pin_oe === 8'hFF) begin
      n_checks++;
      if (n_beat_q.size() == 0) begin
        n_errors++;
        $display("FAIL n_beat: unexpected beat frame=%b out=%h", n_if.pin_frame, n_if.pin_out);
      end else begin
        n_eb = n_beat_q.pop_front();
        if ({n_if.pin_frame, n_if.pin_out} !== n_eb) begin
          n_errors++;
          $display("FAIL n_beat: got frame=%b out=%h, expected frame=%b out=%h",
                   n_if.pin_frame, n_if.pin_out, n_eb[8], n_eb[7:0]);
        end
      end
    end else if (n_if.pin_oe !== 8'h00) begin
      n_checks++;
      n_errors++;
      $display("FAIL n_oe: got %h, expected 00 or FF", n_if.pin_oe);
    end
    if (n_if.rsp_valid === 1'b1) begin
      n_checks++;
      if (n_rsp_q.size() == 0) begin
        n_errors++;
        $display("FAIL n_rsp: unexpected response err=%b rdata=%h", n_if.rsp_err, n_if.rsp_rdata);
      end else begin
        n_er = n_rsp_q.pop_front();
        if ({n_if.rsp_err, n_if.rsp_rdata} !== n_er) begin
          n_errors++;
          $display("FAIL n_rsp: got err=%b rdata=%h, expected err=%b rdata=%h",
                   n_if.rsp_err, n_if.rsp_rdata, n_er[16], n_er[15:0]);
        end
      end
    end
  end

  // ---------------- driver tasks (instance a) ----------------
  task automatic a_push(input logic we, input logic [31:0] addr, input logic [31:0] data);
    a_beat_q.push_back({1'b1, 6'b0, 1'b1, we});
    for (int i = 0; i < A_AB; i++) a_beat_q.push_back({1'b0, addr[i*8 +: 8]});
    if (we) for (int i = 0; i < A_DB; i++) a_beat_q.push_back({1'b0, data[i*8 +: 8]});
    a_rsp_q.push_back({1'b0, (we ? a_last_rdata : data)});
    if (!we) a_last_rdata = data;
  endtask

  task automatic a_accept(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic hold, output int waited);
    a_if.req_we    = we;
    a_if.req_addr  = addr;
    a_if.req_wdata = data;
    a_if.req_valid = 1'b1;
    waited = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (a_if.req_ready === 1'b1) break;
      waited++;
    end
    n_checks++;
    if (waited >= 64) begin
      n_errors++;
      $display("FAIL a_accept: req_ready not seen within %0d cycles", waited);
    end
    @(posedge clk); #1;
    if (!hold) begin
      a_if.req_valid = 1'b0;
      a_if.req_we    = 1'($urandom_range(0, 1));
      a_if.req_addr  = $urandom;
      a_if.req_wdata = $urandom;
    end
  endtask

  // Runs cycles 1..RESP after an accept: drives ack/pin_in, checks busy and latency.
  task automatic a_run(input logic we, input int ack_n, input logic [31:0] rd);
    int first_wait, ack_cyc, resp;
    first_wait = 2 + A_AB + (we ? A_DB : 0);
    ack_cyc    = first_wait + ack_n - 1;
    resp       = ack_cyc + (we ? 0 : A_DB) + 1;
    for (int cyc = 1; cyc <= resp; cyc++) begin
      if (cyc == ack_cyc)                        a_if.pin_ack = 1'b1;
      else if (cyc < first_wait || cyc > ack_cyc) a_if.pin_ack = 1'($urandom_range(0, 1));
      else                                       a_if.pin_ack = 1'b0;
      if (!we && cyc > ack_cyc && cyc <= ack_cyc + A_DB) a_if.pin_in = rd[(cyc-ack_cyc-1)*8 +: 8];
      else                                               a_if.pin_in = 8'($urandom_range(0, 255));
      @(negedge clk);
      n_checks++;
      if (a_if.req_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL a_busy_ready: cycle %0d req_ready=%b, expected 0", cyc, a_if.req_ready);
      end
      n_checks++;
      if (a_if.rsp_valid !== (cyc == resp)) begin
        n_errors++;
        $display("FAIL a_latency: cycle %0d rsp_valid=%b, expected %b", cyc, a_if.rsp_valid, (cyc == resp));
      end
      if (cyc >= first_wait) begin
        n_checks++;
        if (a_if.pin_oe !== 8'h00) begin
          n_errors++;
          $display("FAIL a_oe_off: cycle %0d pin_oe=%h, expected 00", cyc, a_if.pin_oe);
        end
      end
      @(posedge clk); #1;
    end
    a_if.pin_ack = 1'b0;
  endtask

  task automatic a_write(input logic [31:0] addr, input logic [31:0] data, input int ack_n);
    int w;
    a_push(1'b1, addr, data);
    a_accept(1'b1, addr, data, 1'b0, w);
    a_run(1'b1, ack_n, 32'h0);
  endtask

  task automatic a_read(input logic [31:0] addr, input logic [31:0] data, input int ack_n);
    int w;
    a_push(1'b0, addr, data);
    a_accept(1'b0, addr, $urandom, 1'b0, w);
    a_run(1'b0, ack_n, data);
  endtask

  // ---------------- driver tasks (instances t and n) ----------------
  // ack_n == 0 means pin_ack is never raised in WAIT.
  task automatic t_read(input logic [31:0] addr, input logic [31:0] data, input int ack_n);
    int first_wait, ack_cyc, resp, waited;
    first_wait = 2 + T_AB;
    if (ack_n > 0) begin
      ack_cyc = first_wait + ack_n - 1;
      resp    = ack_cyc + T_DB + 1;
      t_rsp_q.push_back({1'b0, data});
    end else begin
      ack_cyc = -1;
      resp    = first_wait + T_TO;
      t_rsp_q.push_back({1'b1, 32'h0});
    end
    t_if.req_we = 1'b0; t_if.req_addr = addr; t_if.req_wdata = $urandom; t_if.req_valid = 1'b1;
    waited = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (t_if.req_ready === 1'b1) break;
      waited++;
    end
    n_checks++;
    if (waited >= 64) begin
      n_errors++;
      $display("FAIL t_accept: req_ready not seen within %0d cycles", waited);
    end
    @(posedge clk); #1;
    t_if.req_valid = 1'b0;
    for (int cyc = 1; cyc <= resp; cyc++) begin
      if (cyc < first_wait) t_if.pin_ack = 1'($urandom_range(0, 1));
      else                  t_if.pin_ack = (cyc == ack_cyc);
      if (ack_n > 0 && cyc > ack_cyc && cyc <= ack_cyc + T_DB) t_if.pin_in = data[(cyc-ack_cyc-1)*8 +: 8];
      else                                                     t_if.pin_in = 8'($urandom_range(0, 255));
      @(negedge clk);
      n_checks++;
      if (t_if.rsp_valid !== (cyc == resp)) begin
        n_errors++;
        $display("FAIL t_latency: cycle %0d rsp_valid=%b, expected %b", cyc, t_if.rsp_valid, (cyc == resp));
      end
      if (cyc >= first_wait) begin
        n_checks++;
        if (t_if.pin_oe !== 8'h00) begin
          n_errors++;
          $display("FAIL t_oe_off: cycle %0d pin_oe=%h, expected 00", cyc, t_if.pin_oe);
        end
      end
      @(posedge clk); #1;
    end
    t_if.pin_ack = 1'b0;
  endtask

  task automatic n_write(input logic [11:0] addr, input logic [15:0] data, input int ack_n);
    logic [15:0] ext;
    int first_wait, ack_cyc, resp, waited;
    ext = {4'b0, addr};
    n_beat_q.push_back({1'b1, 8'h03});
    for (int i = 0; i < N_AB; i++) n_beat_q.push_back({1'b0, ext[i*8 +: 8]});
    for (int i = 0; i < N_DB; i++) n_beat_q.push_back({1'b0, data[i*8 +: 8]});
    n_rsp_q.push_back({1'b0, 16'h0});
    first_wait = 2 + N_AB + N_DB;
    ack_cyc    = first_wait + ack_n - 1;
    resp       = ack_cyc + 1;
    n_if.req_we = 1'b1; n_if.req_addr = addr; n_if.req_wdata = data; n_if.req_valid = 1'b1;
    waited = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (n_if.req_ready === 1'b1) break;
      waited++;
    end
    n_checks++;
    if (waited >= 64) begin
      n_errors++;
      $display("FAIL n_accept: req_ready not seen within %0d cycles", waited);
    end
    @(posedge clk); #1;
    n_if.req_valid = 1'b0;
    for (int cyc = 1; cyc <= resp; cyc++) begin
      n_if.pin_ack = (cyc == ack_cyc);
      @(negedge clk);
      n_checks++;
      if (n_if.rsp_valid !== (cyc == resp)) begin
        n_errors++;
        $display("FAIL n_latency: cycle %0d rsp_valid=%b, expected %b", cyc, n_if.rsp_valid, (cyc == resp));
      end
      @(posedge clk); #1;
    end
    n_if.pin_ack = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (a_if.req_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ready_in_rst: got %b, expected 0", a_if.req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_if.req_ready !== 1'b1 || t_if.req_ready !== 1'b1 || n_if.req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_ready: got a=%b t=%b n=%b, expected 1 1 1",
               a_if.req_ready, t_if.req_ready, n_if.req_ready);
    end
    n_checks++;
    if (a_if.rsp_valid !== 1'b0 || a_if.rsp_err !== 1'b0 || a_if.rsp_rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h, expected 0 0 00000000",
               a_if.rsp_valid, a_if.rsp_err, a_if.rsp_rdata);
    end
    n_checks++;
    if (a_state !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_state: got %0d, expected 0", a_state);
    end
  endtask

  task automatic test_write();
    @(posedge clk); #1;
    a_write(32'h1234_5678, 32'hCAFE_BABE, 3);
  endtask

  task automatic test_read();
    a_read(32'h0000_0010, 32'hDEAD_BEEF, 1);
  endtask

  task automatic test_rst_mid();
    int w;
    a_beat_q.push_back({1'b1, 8'h03});
    a_beat_q.push_back({1'b0, 8'h44});
    a_accept(1'b1, 32'h1122_3344, 32'h5566_7788, 1'b0, w);
    @(posedge clk); #1;          // first ADDR beat
    @(posedge clk); #1;          // second ADDR beat
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_if.pin_oe !== 8'h00 || a_if.req_ready !== 1'b1 || a_if.rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid: got oe=%h ready=%b rsp_valid=%b, expected 00 1 0",
               a_if.pin_oe, a_if.req_ready, a_if.rsp_valid);
    end
    n_checks++;
    if (a_if.rsp_rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL rst_mid_rdata: got %h, expected 00000000", a_if.rsp_rdata);
    end
    a_last_rdata = '0;
    // A stray ack while idle must not produce a response.
    a_if.pin_ack = 1'b1;
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    a_if.pin_ack = 1'b0;
    a_write(32'hA5A5_0F0F, 32'h0102_0304, 2);
  endtask

  task automatic test_random();
    logic        we;
    logic [31:0] addr, data;
    for (int i = 0; i < 6; i++) begin
      we   = 1'($urandom_range(0, 1));
      addr = $urandom;
      data = $urandom;
      if (we) a_write(addr, data, $urandom_range(1, 16));
      else    a_read(addr, data, $urandom_range(1, 16));
    end
  endtask

  task automatic test_back_to_back();
    int w;
    a_push(1'b1, 32'h0000_1000, 32'h1111_2222);
    a_push(1'b1, 32'h0000_2000, 32'h3333_4444);
    a_accept(1'b1, 32'h0000_1000, 32'h1111_2222, 1'b1, w);
    a_if.req_addr  = 32'h0000_2000;
    a_if.req_wdata = 32'h3333_4444;
    a_run(1'b1, 2, 32'h0);
    a_accept(1'b1, 32'h0000_2000, 32'h3333_4444, 1'b0, w);
    n_checks++;
    if (w !== 0) begin
      n_errors++;
      $display("FAIL b2b_accept: second request waited %0d cycles after response, expected 0", w);
    end
    a_run(1'b1, 1, 32'h0);
  endtask

  task automatic test_timeout();
    t_read(32'h0000_0100, 32'hA5A5_5A5A, T_TO);   // ack on final WAIT cycle
    t_read(32'h0000_0104, 32'h0, 0);              // no ack: error response
    t_read(32'h0000_0108, 32'h0BAD_F00D, 1);      // recovers after error
  endtask

  task automatic test_narrow();
    n_write(12'hABC, 16'h1234, 1);
    n_write(12'hFFF, 16'hFFFF, 3);
  endtask

  // ---------------- main ----------------
  initial begin
    a_if.req_valid = 1'b0; a_if.req_we = 1'b0; a_if.req_addr = '0; a_if.req_wdata = '0;
    a_if.pin_in = '0; a_if.pin_ack = 1'b0;
    t_if.req_valid = 1'b0; t_if.req_we = 1'b0; t_if.req_addr = '0; t_if.req_wdata = '0;
    t_if.pin_in = '0; t_if.pin_ack = 1'b0;
    n_if.req_valid = 1'b0; n_if.req_we = 1'b0; n_if.req_addr = '0; n_if.req_wdata = '0;
    n_if.pin_in = '0; n_if.pin_ack = 1'b0;

    test_reset();
    test_write();
    test_read();
    test_rst_mid();
    test_random();
    test_back_to_back();
    test_timeout();
    test_narrow();
    repeat (3) @(posedge clk);

    n_checks++;
    if (a_beat_q.size() != 0 || a_rsp_q.size() != 0 || t_rsp_q.size() != 0 ||
        n_beat_q.size() != 0 || n_rsp_q.size() != 0) begin
      n_errors++;
      $display("FAIL leftover: beats a=%0d n=%0d rsps a=%0d t=%0d n=%0d, expected all 0",
               a_beat_q.size(), n_beat_q.size(), a_rsp_q.size(), t_rsp_q.size(), n_rsp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
